vlsu_req_sched: RTL and testbench

VLSU_REQ_SCHED -- requirements
Module: vlsu_req_sched

---
 rtl/vlsu_req_sched.sv | 117 +++++++++++
 tb/tb_vlsu_req_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_req_sched.sv
// Serialising request scheduler in front of the VLSU ControlMachine.
// Round-robin grant with load/store ordering against outstanding stores.
module vlsu_req_sched #(
    parameter int unsigned NrReq    = 2,
    parameter int unsigned MaxStOut = 4,
    parameter type         vlsu_req_t = logic,
    localparam int unsigned PtrW = (NrReq > 1) ? $clog2(NrReq) : 1,
    localparam int unsigned CntW = $clog2(MaxStOut + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic      [NrReq-1:0]       req_valid_i,
    output logic      [NrReq-1:0]       req_ready_o,
    input  vlsu_req_t [NrReq-1:0]       req_i,
    input  logic      [NrReq-1:0]       req_is_store_i,
    output logic                        vlsu_req_valid_o,
    input  logic                        vlsu_req_ready_i,
    output vlsu_req_t                   vlsu_req_o,
    input  logic                        st_done_i,
    output logic                        st_pending_o,
    output logic      [CntW-1:0]        st_cnt_o,
    output logic                        err_o
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxStOut);

    state_t            state;
    logic [PtrW-1:0]   ptr;
    logic [CntW-1:0]   st_cnt;
    logic              buf_store;
    logic [NrReq-1:0]  elig;
    logic              gnt_any;
    logic [PtrW-1:0]   gnt_idx;
    logic              st_inc;
    logic              st_dec;

    function automatic logic [PtrW-1:0] wrap(input int unsigned v);
        return PtrW'(v % NrReq);
    endfunction

    // Loads wait for all stores to drain; stores only need a free slot.
    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            elig[i] = req_valid_i[i] &&
                      (req_is_store_i[i] ? (st_cnt < MaxCnt) : (st_cnt == '0));
        end
    end

    // Walk downward so the candidate closest to the pointer wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NrReq - 1; k >= 0; k--) begin
            if (elig[wrap(32'(ptr) + 32'(k))]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap(32'(ptr) + 32'(k));
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (!rst_i && state == IDLE && gnt_any) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign st_inc = (state == HOLD) && vlsu_req_ready_i && buf_store;
    assign st_dec = st_done_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ptr        <= '0;
            st_cnt     <= '0;
            err_o      <= 1'b0;
            buf_store  <= 1'b0;
            vlsu_req_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        vlsu_req_o <= req_i[gnt_idx];
                        buf_store  <= req_is_store_i[gnt_idx];
                        ptr        <= wrap(32'(gnt_idx) + 32'd1);
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (vlsu_req_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (st_inc && !st_dec) begin
                if (st_cnt != MaxCnt) begin
                    st_cnt <= st_cnt + 1'b1;
                end
            end else if (!st_inc && st_dec) begin
                if (st_cnt != '0) begin
                    st_cnt <= st_cnt - 1'b1;
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

    assign vlsu_req_valid_o = (state == HOLD);
    assign st_cnt_o         = st_cnt;
    assign st_pending_o     = (st_cnt != '0) || ((state == HOLD) && buf_store);

endmodule

// File: tb/tb_vlsu_req_sched.sv
// Scoreboard bench for vlsu_req_sched: a cycle model predicts grants and
// counters, granted payloads queue up and are checked at the ControlMachine side.
module tb_vlsu_req_sched;

    typedef logic [7:0] pl_t;
    typedef struct packed {
        pl_t  d;
        logic s;
    } sb_t;

    logic            clk = 1'b0;
    logic            rst;
    logic      [1:0] valid;
    logic      [1:0] rdy_o;
    pl_t       [1:0] pl;
    logic      [1:0] st;
    logic            vv;
    logic            vr;
    pl_t             vd;
    logic            done;
    logic            pend;
    logic      [2:0] cnt;
    logic            err;

    always #5 clk = ~clk;

    vlsu_req_sched #(
        .NrReq      (2),
        .MaxStOut   (4),
        .vlsu_req_t (pl_t)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_valid_i      (valid),
        .req_ready_o      (rdy_o),
        .req_i            (pl),
        .req_is_store_i   (st),
        .vlsu_req_valid_o (vv),
        .vlsu_req_ready_i (vr),
        .vlsu_req_o       (vd),
        .st_done_i        (done),
        .st_pending_o     (pend),
        .st_cnt_o         (cnt),
        .err_o            (err)
    );

    int  n_chk = 0;
    int  n_err = 0;
    sb_t q[$];
    int  grants[$];
    bit  m_hold;
    bit  m_store;
    bit  m_err;
    int  m_ptr;
    int  m_cnt;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int       w;
        logic [1:0] er;
        bit       inc;
        sb_t      e;
        #1;
        if (rst) begin
            m_hold = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_store = 0;
            q.delete();
            check("rst_data", 32'(vd), 0);
        end
        w  = -1;
        er = '0;
        if (!rst && !m_hold) begin
            for (int k = 0; k < 2; k++) begin
                int i;
                i = (m_ptr + k) % 2;
                if (w < 0 && valid[i] && (st[i] ? m_cnt < 4 : m_cnt == 0))
                    w = i;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        check("ready", 32'(rdy_o), 32'(er));
        check("valid", 32'(vv), 32'(m_hold));
        check("cnt", 32'(cnt), 32'(m_cnt));
        check("pend", 32'(pend), 32'((m_cnt != 0) || (m_hold && m_store)));
        check("err", 32'(err), 32'(m_err));
        if (rdy_o != 2'b00) grants.push_back(rdy_o[1] ? 1 : 0);
        if (!rst && m_hold) begin
            if (q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = q[0];
                check("data", 32'(vd), 32'(e.d));
                if (vr) void'(q.pop_front());
            end
        end
        if (w >= 0) q.push_back('{d: pl[w], s: st[w]});
        @(posedge clk);
        if (!rst) begin
            inc = m_hold && vr && m_store;
            if (m_hold) begin
                if (vr) m_hold = 0;
            end else if (w >= 0) begin
                m_hold  = 1;
                m_ptr   = (w + 1) % 2;
                m_store = st[w];
            end
            if (inc && !done) begin
                if (m_cnt < 4) m_cnt++;
            end else if (!inc && done) begin
                if (m_cnt > 0) m_cnt--;
                else m_err = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int g0;
        rst = 1'b1; valid = '0; st = '0; vr = 1'b0; done = 1'b0;
        pl[0] = 8'h00; pl[1] = 8'h00;
        @(negedge clk);
        cyc();
        cyc();
        check("rst_vv", 32'(vv), 0);
        rst = 1'b0;

        // Alternating loads with a always-ready ControlMachine
        valid = 2'b11; st = 2'b00; vr = 1'b1;
        pl[0] = 8'h10; pl[1] = 8'h21;
        g0 = grants.size();
        for (int c = 0; c < 8; c++) begin
            pl[0] = pl[0] + 8'd2; pl[1] = pl[1] + 8'd2;
            cyc();
        end
        check("n_grants", 32'(grants.size() - g0), 4);
        check("g0", 32'(grants[g0]), 0);
        check("g1", 32'(grants[g0 + 1]), 1);
        check("g2", 32'(grants[g0 + 2]), 0);
        check("g3", 32'(grants[g0 + 3]), 1);

        // Load waits behind an outstanding store
        valid = 2'b01; st = 2'b01; pl[0] = 8'h5a;
        cyc();
        valid = 2'b00;
        cyc();
        valid = 2'b10; st = 2'b00; pl[1] = 8'h3c;
        for (int c = 0; c < 5; c++) cyc();
        check("ld_blocked", 32'(rdy_o), 0);
        check("ld_pend", 32'(pend), 1);
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("ld_go", 32'(rdy_o), 32'(2'b10));
        cyc();
        valid = 2'b00;
        cyc();
        check("pend_clr", 32'(pend), 0);

        // Store window fills at four
        do_reset();
        valid = 2'b01; st = 2'b01; vr = 1'b1;
        g0 = grants.size();
        for (int c = 0; c < 12; c++) begin
            pl[0] = 8'(8'h80 + c);
            cyc();
        end
        check("st_grants", 32'(grants.size() - g0), 4);
        check("st_full", 32'(cnt), 4);
        check("st_stall", 32'(rdy_o), 0);
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("st_fifth", 32'(rdy_o), 32'(2'b01));
        cyc();
        cyc();

        // Store issue and completion in the same cycle
        do_reset();
        valid = 2'b01; st = 2'b01; vr = 1'b1;
        for (int c = 0; c < 5; c++) cyc();
        valid = 2'b00; done = 1'b1;
        cyc();
        done = 1'b0;
        check("st_same", 32'(cnt), 2);

        // Spurious completion is sticky
        do_reset();
        done = 1'b1;
        cyc();
        done = 1'b0;
        check("err_set", 32'(err), 1);
        check("err_cnt", 32'(cnt), 0);
        for (int c = 0; c < 3; c++) cyc();
        check("err_stick", 32'(err), 1);

        // Back-pressure in HOLD, then reset discards the request
        do_reset();
        valid = 2'b01; st = 2'b00; vr = 1'b0; pl[0] = 8'ha5;
        cyc();
        valid = 2'b00; pl[0] = 8'h00;
        for (int c = 0; c < 10; c++) cyc();
        check("hold_data", 32'(vd), 32'h0a5);
        rst = 1'b1;
        cyc();
        check("rst_vd", 32'(vd), 0);
        check("rst_rdy", 32'(rdy_o), 0);
        check("rst_pend", 32'(pend), 0);
        rst = 1'b0;
        valid = 2'b11; pl[0] = 8'h11; pl[1] = 8'h22;
        #1;
        check("rst_ptr", 32'(rdy_o), 32'(2'b01));
        cyc();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            valid = 2'($urandom_range(0, 3));
            st    = 2'($urandom_range(0, 3));
            pl[0] = 8'($urandom);
            pl[1] = 8'($urandom);
            vr    = 1'($urandom_range(0, 1));
            done  = (m_cnt > 0) && ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
